am74ls251_scan: RTL

//  Scan sequencer for an am74ls251 8-to-1 tri-state mux. Drives the select lines
//  {c,b,a} and the strobe s_, samples y once per enabled channel, and assembles
//  the bits into a parallel byte.

---
 rtl/am74ls251_scan.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/am74ls251_scan.sv
// Scan sequencer for an am74ls251 8-to-1 mux: walks the enabled channels,
// samples y after a settle window and publishes the byte with a change mask.
module am74ls251_scan #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       start,
    input  logic       cont,
    input  logic [7:0] en,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       s_,
    output logic       busy,
    output logic       done,
    output logic [7:0] q,
    output logic [7:0] chg
);

    typedef enum logic [1:0] {IDLE, SEL, WAIT, DONE} state_t;

    state_t     state, state_n;
    logic [2:0] ch, ch_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] msk, msk_n;
    logic [7:0] shadow, shadow_n;
    logic [7:0] q_n, chg_n;
    logic       busy_n, done_n;
    logic       capture, launch;
    logic [3:0] first_hit, next_hit;

    // Lowest set bit of m at or above lo; bit 3 of the result flags a hit.
    function automatic logic [3:0] find_ch(input logic [7:0] m, input logic [3:0] lo);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i] && (i >= int'(lo)))
                r = {1'b1, 3'(i)};
        return r;
    endfunction

    assign first_hit = find_ch(en, 4'd0);
    assign next_hit  = find_ch(msk, {1'b0, ch} + 4'd1);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_n  = state;
        ch_n     = ch;
        cnt_n    = cnt;
        msk_n    = msk;
        shadow_n = shadow;
        q_n      = q;
        chg_n    = chg;
        busy_n   = busy;
        done_n   = 1'b0;
        capture  = 1'b0;
        launch   = 1'b0;

        case (state)
            IDLE: launch = start;
            SEL: begin
                if (SETTLE == 0) begin
                    capture = 1'b1;
                end else begin
                    cnt_n   = 4'(SETTLE);
                    state_n = WAIT;
                end
            end
            WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1)
                    capture = 1'b1;
            end
            DONE: begin
                q_n    = shadow;
                chg_n  = shadow ^ q;
                done_n = 1'b1;
                if (cont) begin
                    launch = 1'b1;
                end else begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        // Captures chain straight into the next address so s_ stays low across channels.
        if (capture) begin
            shadow_n[ch] = y;
            if (next_hit[3]) begin
                ch_n    = next_hit[2:0];
                state_n = SEL;
            end else begin
                state_n = DONE;
            end
        end

        if (launch) begin
            msk_n    = en;
            shadow_n = 8'h00;
            busy_n   = 1'b1;
            if (first_hit[3]) begin
                ch_n    = first_hit[2:0];
                state_n = SEL;
            end else begin
                state_n = DONE;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state  <= IDLE;
            ch     <= 3'd0;
            cnt    <= 4'd0;
            msk    <= 8'h00;
            shadow <= 8'h00;
            q      <= 8'h00;
            chg    <= 8'h00;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            ch     <= ch_n;
            cnt    <= cnt_n;
            msk    <= msk_n;
            shadow <= shadow_n;
            q      <= q_n;
            chg    <= chg_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    assign {c, b, a} = ch;
    assign s_        = !((state == SEL) || (state == WAIT));

endmodule
